// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared constants and state type for the tone generator
package music_pkg;

   localparam int DEF_CLK_HZ = 50_000_000;
   localparam int DEF_FREQ_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      RUN    = 2'd2
   } tone_state_t;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider, one quotient bit per clock
// quotient/done are valid combinationally during the last iteration cycle so the
// caller can capture the result on the same edge that retires the final bit.
module seq_divider #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W:0]   divisor,
   output logic [W-1:0] quotient,
   output logic         done
);

   localparam int CNT_W = $clog2(W + 1);

   logic [W:0]       rem_q, rem_d;
   logic [W-1:0]     quo_q, quo_d;
   logic [W:0]       div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d;

   logic [W+1:0]     shifted;
   logic [W+1:0]     trial;
   logic             qbit;
   logic [W:0]       rem_next;
   logic             last;

   always_comb begin
      shifted  = {rem_q, quo_q[W-1]};
      trial    = shifted - {1'b0, div_q};
      qbit     = ~trial[W+1];
      rem_next = qbit ? trial[W:0] : shifted[W:0];
      last     = (cnt_q == CNT_W'(W - 1));
      quotient = {quo_q[W-2:0], qbit};
      done     = run_q && last;
   end

   // quo_q shifts dividend bits out of the top and quotient bits in at the bottom
   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      div_d = div_q;
      cnt_d = cnt_q;
      run_d = run_q;
      if (start) begin
         rem_d = '0;
         quo_d = dividend;
         div_d = divisor;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         rem_d = rem_next;
         quo_d = quotient;
         cnt_d = cnt_q + CNT_W'(1);
         run_d = !last;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         div_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         div_q <= div_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - 50% duty square-wave tone generator driven by a frequency in Hz
module tone_gen
   import music_pkg::*;
#(
   parameter int CLK_HZ = DEF_CLK_HZ,
   parameter int FREQ_W = DEF_FREQ_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FREQ_W-1:0] note_freq,
   input  logic              enable,
   output logic              tone_out,
   output logic              busy,
   output logic [FREQ_W-1:0] half_period
);

   tone_state_t       state_q, state_d;
   logic [FREQ_W-1:0] freq_q, freq_d;
   logic [FREQ_W-1:0] cnt_q, cnt_d;
   logic [FREQ_W-1:0] hp_q, hp_d;
   logic              tone_q, tone_d;
   logic              busy_q, busy_d;

   logic              chg;
   logic              start;
   logic [FREQ_W-1:0] quotient;
   logic              div_done;

   assign chg   = (note_freq != freq_q);
   assign start = chg && (note_freq != '0);

   seq_divider #(.W(FREQ_W)) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .dividend (FREQ_W'(CLK_HZ)),
      .divisor  ({note_freq, 1'b0}),
      .quotient (quotient),
      .done     (div_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         freq_q  <= '0;
         cnt_q   <= '0;
         hp_q    <= '0;
         tone_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         freq_q  <= freq_d;
         cnt_q   <= cnt_d;
         hp_q    <= hp_d;
         tone_q  <= tone_d;
         busy_q  <= busy_d;
      end
   end

   // a frequency change outranks divide completion, discarding a pending result
   always_comb begin
      state_d = state_q;
      if (chg) begin
         state_d = (note_freq != '0) ? DIVIDE : IDLE;
      end else if (state_q == DIVIDE && div_done) begin
         state_d = RUN;
      end
   end

   always_comb begin
      freq_d = freq_q;
      cnt_d  = cnt_q;
      hp_d   = hp_q;
      tone_d = tone_q;
      busy_d = busy_q;
      if (chg) begin
         freq_d = note_freq;
         tone_d = 1'b0;
         cnt_d  = '0;
         busy_d = (note_freq != '0);
         if (note_freq == '0) hp_d = '0;
      end else begin
         case (state_q)
            DIVIDE: begin
               tone_d = 1'b0;
               if (div_done) begin
                  hp_d   = (quotient == '0) ? FREQ_W'(1) : quotient;
                  busy_d = 1'b0;
                  cnt_d  = '0;
               end
            end
            RUN: begin
               if (!enable) begin
                  tone_d = 1'b0;
                  cnt_d  = '0;
               end else if (cnt_q == hp_q - FREQ_W'(1)) begin
                  tone_d = ~tone_q;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + FREQ_W'(1);
               end
            end
            default: tone_d = 1'b0;
         endcase
      end
   end

   assign tone_out    = tone_q;
   assign busy        = busy_q;
   assign half_period = hp_q;

endmodule

// File: tb/tb_tone_gen.sv
// tb/tb_tone_gen.sv - directed bench for tone_gen at CLK_HZ=1000 and default clock
module tb_tone_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] note_a, note_b;
   logic        tone_a, busy_a, tone_b, busy_b;
   logic [31:0] hp_a, hp_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   tone_gen #(.CLK_HZ(1000), .FREQ_W(32)) dut_a (
      .clk(clk), .reset(reset), .note_freq(note_a), .enable(enable),
      .tone_out(tone_a), .busy(busy_a), .half_period(hp_a)
   );

   tone_gen dut_b (
      .clk(clk), .reset(reset), .note_freq(note_b), .enable(enable),
      .tone_out(tone_b), .busy(busy_b), .half_period(hp_b)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // call on the negedge right after the change edge; returns on the negedge busy fell
   task automatic busy_len(input bit sel, output int n);
      n = (sel ? busy_b : busy_a) ? 1 : 0;
      while ((sel ? busy_b : busy_a) && n < 100) begin
         tick(1);
         if (sel ? busy_b : busy_a) n++;
      end
   endtask

   int  n;
   bit  ok;

   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      note_a = 0;
      note_b = 0;
      tick(3);
      reset = 1'b0;
      check("rst_tone", {31'd0, tone_a}, 0);
      check("rst_busy", {31'd0, busy_a}, 0);
      check("rst_hp",   hp_a, 0);
      check("rst_hp_b", hp_b, 0);

      // 1000 Hz clock, 100 Hz tone -> half period 5
      note_a = 100;
      tick(1);
      check("busy_rise", {31'd0, busy_a}, 1);
      busy_len(0, n);
      check("busy_len_100", n, 32);
      check("hp_100", hp_a, 5);
      check("tone_at_done", {31'd0, tone_a}, 0);
      tick(4);
      check("tone_pre_rise", {31'd0, tone_a}, 0);
      tick(1);
      check("first_rise", {31'd0, tone_a}, 1);
      tick(4);
      check("high_hold", {31'd0, tone_a}, 1);
      tick(1);
      check("first_fall", {31'd0, tone_a}, 0);
      tick(5);
      check("second_rise", {31'd0, tone_a}, 1);

      // enable low for 7 cycles, then restart from a full half period
      enable = 1'b0;
      ok = 1'b1;
      repeat (7) begin
         tick(1);
         if (tone_a !== 1'b0) ok = 1'b0;
      end
      check("en_low_silent", {31'd0, ok}, 1);
      enable = 1'b1;
      tick(4);
      check("en_restart_low", {31'd0, tone_a}, 0);
      tick(1);
      check("en_restart_rise", {31'd0, tone_a}, 1);

      // zero frequency silences on the next edge
      note_a = 0;
      tick(1);
      check("zero_tone", {31'd0, tone_a}, 0);
      check("zero_busy", {31'd0, busy_a}, 0);
      check("zero_hp", hp_a, 0);
      ok = 1'b1;
      repeat (20) begin
         tick(1);
         if (tone_a !== 1'b0 || busy_a !== 1'b0) ok = 1'b0;
      end
      check("zero_held", {31'd0, ok}, 1);

      // change mid-divide restarts; the 100 Hz result must never surface
      note_a = 100;
      tick(10);
      note_a = 200;
      tick(1);
      ok = 1'b1;
      n = 1;
      while (busy_a && n < 100) begin
         if (hp_a == 5) ok = 1'b0;
         tick(1);
         if (busy_a) n++;
      end
      check("restart_busy_len", n, 32);
      check("restart_no_stale", {31'd0, ok}, 1);
      check("hp_200", hp_a, 2);
      tick(2);
      check("hp2_rise", {31'd0, tone_a}, 1);
      tick(2);
      check("hp2_fall", {31'd0, tone_a}, 0);

      // quotient 0 clamps to 1: toggle every clock
      note_a = 600;
      tick(1);
      busy_len(0, n);
      check("hp_clamp", hp_a, 1);
      tick(1);
      check("clamp_rise", {31'd0, tone_a}, 1);
      tick(1);
      check("clamp_fall", {31'd0, tone_a}, 0);
      tick(1);

      // reset mid-RUN
      reset  = 1'b1;
      note_a = 0;
      tick(1);
      check("rst_run_tone", {31'd0, tone_a}, 0);
      check("rst_run_hp", hp_a, 0);
      reset = 1'b0;

      // reset mid-DIVIDE
      note_a = 100;
      tick(5);
      check("mid_div_busy", {31'd0, busy_a}, 1);
      reset  = 1'b1;
      note_a = 0;
      tick(1);
      check("rst_div_busy", {31'd0, busy_a}, 0);
      check("rst_div_hp", hp_a, 0);
      reset = 1'b0;
      ok = 1'b1;
      repeat (40) begin
         tick(1);
         if (tone_a !== 1'b0 || busy_a !== 1'b0 || hp_a !== 0) ok = 1'b0;
      end
      check("post_rst_silent", {31'd0, ok}, 1);

      // default 50 MHz clock
      note_b = 440;
      tick(1);
      busy_len(1, n);
      check("busy_len_440", n, 32);
      check("hp_440", hp_b, 56818);
      note_b = 220;
      tick(1);
      busy_len(1, n);
      check("busy_len_220", n, 32);
      check("hp_220", hp_b, 113636);
      tick(3);
      check("hp_220_hold", hp_b, 113636);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
